// File: rtl/alu_mult_seq.sv
// Sequential 64x64 unsigned shift-add multiplier that borrows an external 64-bit ALU for its adds.
// Optional early termination once the remaining multiplier bits are zero: define MULT_EARLY_TERM_EN.
module alu_mult_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [63:0]  mcand,
    input  logic [63:0]  mplier,
    output logic         busy,
    output logic         done,
    output logic [127:0] product,
    output logic [63:0]  alu_a,
    output logic [63:0]  alu_b,
    output logic [2:0]   alu_cntrl,
    input  logic [63:0]  alu_result,
    input  logic         alu_carry_out
);
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] ITERS   = CW'(64);
    localparam logic [2:0]    ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  mc_q, mc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic          early;
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0]  rem_q, rem_d;
`endif

    // Next state, datapath update, and next values of the registered outputs
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mc_d    = mc_q;
        cnt_d   = cnt_q;
`ifdef MULT_EARLY_TERM_EN
        rem_d   = rem_q;
        early   = (rem_q == '0);
`else
        early   = 1'b0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    hi_d    = '0;
                    lo_d    = mplier;
                    mc_d    = mcand;
                    cnt_d   = ITERS;
`ifdef MULT_EARLY_TERM_EN
                    rem_d   = mplier;
`endif
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (early) begin
                    // Remaining multiplier bits are zero: align the partial product in one step
                    {hi_d, lo_d} = {hi_q, lo_q} >> cnt_q;
                    cnt_d        = '0;
                    state_d      = S_DONE;
                end else begin
                    {hi_d, lo_d} = {alu_carry_out, alu_result, lo_q[W-1:1]};
                    cnt_d        = cnt_q - CW'(1);
`ifdef MULT_EARLY_TERM_EN
                    rem_d        = rem_q >> 1;
`endif
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // ALU operands are registered so they line up with hi/lo during each RUN cycle
        busy_d  = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
        alu_a_d = busy_d ? hi_d : '0;
        alu_b_d = (busy_d && lo_d[0]) ? mc_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
`ifdef MULT_EARLY_TERM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
`ifdef MULT_EARLY_TERM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = {hi_q, lo_q};
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cntrl = ALU_ADD;

endmodule
